// File: rtl/rf_weight_loader_pkg.sv
// Shared widths, TUSER field layout, opcodes and FSM state for the RF weight loader.
package rf_weight_loader_pkg;

  localparam int unsigned DATAW = 512;
  localparam int unsigned DESTW = 12;
  localparam int unsigned IDW   = 4;

  localparam int unsigned TUSER_ADDR_LSB = 0;
  localparam int unsigned TUSER_OP_LSB   = 9;
  localparam int unsigned TUSER_SEL_LSB  = 11;

  // One-hot select covers 64 register files above the opcode field.
  localparam int unsigned USERW = TUSER_SEL_LSB + 64;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_RF_WRITE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/rf_weight_loader_if.sv
// Weight-word input stream plus the AXI-Stream RF write port toward mvm_top.
interface rf_weight_loader_if
  import rf_weight_loader_pkg::*;
  ();

  logic             IN_VALID;
  logic [DATAW-1:0] IN_DATA;
  logic             IN_READY;

  logic             AXIS_M_TVALID;
  logic             AXIS_M_TREADY;
  logic [DATAW-1:0] AXIS_M_TDATA;
  logic             AXIS_M_TLAST;
  logic [IDW-1:0]   AXIS_M_TID;
  logic [USERW-1:0] AXIS_M_TUSER;
  logic [DESTW-1:0] AXIS_M_TDEST;

  // Loader side: consumes weight words, drives the AXIS beats.
  modport master (
    input  IN_VALID, IN_DATA, AXIS_M_TREADY,
    output IN_READY, AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER,
           AXIS_M_TDEST
  );

  modport slave (
    output IN_VALID, IN_DATA, AXIS_M_TREADY,
    input  IN_READY, AXIS_M_TVALID, AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TID, AXIS_M_TUSER,
           AXIS_M_TDEST
  );

endinterface

// File: rtl/rf_weight_loader_axis_out_reg.sv
// Single-entry AXIS output register; holds its contents while stalled downstream.
module rf_weight_loader_axis_out_reg
  import rf_weight_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DATAW-1:0] nxt_data,
  input  logic [USERW-1:0] nxt_user,
  input  logic [DESTW-1:0] nxt_dest,
  input  logic             tready,
  output logic             tvalid,
  output logic [DATAW-1:0] tdata,
  output logic [USERW-1:0] tuser,
  output logic [DESTW-1:0] tdest,
  output logic [IDW-1:0]   tid,
  output logic             tlast
);

  // load is only raised when the slot is empty or draining, so a load replaces the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tuser  <= '0;
      tdest  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= nxt_data;
      tuser  <= nxt_user;
      tdest  <= nxt_dest;
      tlast  <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

  assign tid = '0;

endmodule

// File: rtl/rf_weight_loader.sv
// Turns a flat weight-word stream into single-beat RF write packets, walking rows x RFs.
module rf_weight_loader
  import rf_weight_loader_pkg::*;
#(
  parameter int unsigned NUM_RF = 64,
  parameter int unsigned ADDRW  = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [DESTW-1:0] CFG_DEST,
  input  logic [ADDRW-1:0] CFG_BASE_ADDR,
  input  logic [ADDRW:0]   CFG_NUM_ROWS,
  input  logic [1:0]       CFG_OP,
  rf_weight_loader_if.master bus,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned RFW = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;

  state_e           state_q, state_d;
  logic [ADDRW:0]   row_q, row_d, rows_q;
  logic [RFW-1:0]   rf_q, rf_d;
  logic [ADDRW-1:0] base_q, addr;
  logic [1:0]       op_q;
  logic [DESTW-1:0] dest_q;
  logic             done_q, done_d;
  logic             accept, out_hs, last_word;
  logic [NUM_RF-1:0] sel;
  logic [USERW-1:0]  nxt_user;

  assign out_hs    = bus.AXIS_M_TVALID && bus.AXIS_M_TREADY;
  assign bus.IN_READY = (state_q == StRun) && (!bus.AXIS_M_TVALID || bus.AXIS_M_TREADY);
  assign accept    = bus.IN_VALID && bus.IN_READY;
  assign last_word = (rf_q == RFW'(NUM_RF - 1)) && (row_q == rows_q - (ADDRW+1)'(1));

  assign addr     = base_q + row_q[ADDRW-1:0];
  assign sel      = NUM_RF'(1) << rf_q;
  assign nxt_user = USERW'({sel, op_q, addr});

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rf_d    = rf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          if (CFG_NUM_ROWS != '0) begin
            state_d = StRun;
            row_d   = '0;
            rf_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (rf_q == RFW'(NUM_RF - 1)) begin
            rf_d  = '0;
            row_d = row_q + (ADDRW+1)'(1);
            if (last_word) state_d = StDrain;
          end else begin
            rf_d = rf_q + RFW'(1);
          end
        end
      end
      StDrain: begin
        if (out_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      row_q   <= '0;
      rf_q    <= '0;
      rows_q  <= '0;
      base_q  <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rf_q    <= rf_d;
      done_q  <= done_d;
      if (state_q == StIdle && START) begin
        rows_q <= CFG_NUM_ROWS;
        base_q <= CFG_BASE_ADDR;
        op_q   <= CFG_OP;
        dest_q <= CFG_DEST;
      end
    end
  end

  rf_weight_loader_axis_out_reg u_out_reg (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .nxt_data (bus.IN_DATA),
    .nxt_user (nxt_user),
    .nxt_dest (dest_q),
    .tready   (bus.AXIS_M_TREADY),
    .tvalid   (bus.AXIS_M_TVALID),
    .tdata    (bus.AXIS_M_TDATA),
    .tuser    (bus.AXIS_M_TUSER),
    .tdest    (bus.AXIS_M_TDEST),
    .tid      (bus.AXIS_M_TID),
    .tlast    (bus.AXIS_M_TLAST)
  );

  // Final DONE is combinational so it coincides with the last beat's handshake.
  assign DONE = done_q || (state_q == StDrain && out_hs);
  assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_rf_weight_loader.sv
// Randomized directed bench for rf_weight_loader with a job-level reference model.
module tb_rf_weight_loader;
  import rf_weight_loader_pkg::*;

  localparam int unsigned NUM_RF = 64;
  localparam int unsigned ADDRW  = 9;
  localparam int          LIMIT  = 5000;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [DESTW-1:0] CFG_DEST;
  logic [ADDRW-1:0] CFG_BASE_ADDR;
  logic [ADDRW:0]   CFG_NUM_ROWS;
  logic [1:0]       CFG_OP;
  logic             BUSY;
  logic             DONE;

  rf_weight_loader_if bus ();

  rf_weight_loader #(
    .NUM_RF (NUM_RF),
    .ADDRW  (ADDRW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START         (START),
    .CFG_DEST      (CFG_DEST),
    .CFG_BASE_ADDR (CFG_BASE_ADDR),
    .CFG_NUM_ROWS  (CFG_NUM_ROWS),
    .CFG_OP        (CFG_OP),
    .bus           (bus),
    .BUSY          (BUSY),
    .DONE          (DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: job config, FIFO of accepted words, beats emitted so far.
  logic [DATAW-1:0] in_q[$];
  logic [ADDRW-1:0] m_base;
  logic [1:0]       m_op;
  logic [DESTW-1:0] m_dest;
  int               total, beats_out;
  bit               busy_now, zero_now;
  bit               drv_start;
  bit               stall_prev;
  logic [DATAW-1:0] s_data;
  logic [USERW-1:0] s_user;
  logic [DESTW-1:0] s_dest;
  logic [IDW-1:0]   s_id;
  logic             s_last;

  task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] rand_word();
    logic [DATAW-1:0] w;
    for (int i = 0; i < DATAW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [USERW-1:0] exp_user(input int k);
    logic [USERW-1:0] u;
    int r, f;
    r = k / NUM_RF;
    f = k % NUM_RF;
    u = '0;
    u[TUSER_ADDR_LSB +: ADDRW] = ADDRW'((int'(m_base) + r) % (1 << ADDRW));
    u[TUSER_OP_LSB +: 2]       = m_op;
    u[TUSER_SEL_LSB + f]       = 1'b1;
    return u;
  endfunction

  task automatic cycle(input bit iv, input bit tr);
    bit busy_next, zero_next, hs, exp_done;
    logic [DATAW-1:0] w;
    @(negedge CLK);
    bus.IN_VALID      = iv;
    bus.IN_DATA       = rand_word();
    bus.AXIS_M_TREADY = tr;
    START             = drv_start;
    #1;
    busy_next = busy_now;
    zero_next = 1'b0;
    exp_done  = zero_now;
    chk("busy", BUSY, busy_now);
    if (!busy_now) begin
      chk("in_ready_idle", bus.IN_READY, 1'b0);
      chk("tvalid_idle", bus.AXIS_M_TVALID, 1'b0);
    end
    if (stall_prev) begin
      chk("stall_tvalid", bus.AXIS_M_TVALID, 1'b1);
      chk("stall_tdata", bus.AXIS_M_TDATA, s_data);
      chk("stall_tuser", bus.AXIS_M_TUSER, s_user);
      chk("stall_tdest", bus.AXIS_M_TDEST, s_dest);
      chk("stall_tid", bus.AXIS_M_TID, s_id);
      chk("stall_tlast", bus.AXIS_M_TLAST, s_last);
    end
    hs = bus.AXIS_M_TVALID && bus.AXIS_M_TREADY;
    if (hs) begin
      chk("beat_has_word", in_q.size() != 0, 1'b1);
      if (in_q.size() != 0) begin
        w = in_q.pop_front();
        chk("tdata", bus.AXIS_M_TDATA, w);
      end
      chk("tuser", bus.AXIS_M_TUSER, exp_user(beats_out));
      chk("tdest", bus.AXIS_M_TDEST, m_dest);
      chk("tid", bus.AXIS_M_TID, '0);
      chk("tlast", bus.AXIS_M_TLAST, 1'b1);
      beats_out++;
      if (beats_out == total) begin
        exp_done  = 1'b1;
        busy_next = 1'b0;
      end
    end
    if (bus.IN_VALID && bus.IN_READY) in_q.push_back(bus.IN_DATA);
    chk("done", DONE, exp_done);
    if (START && !busy_now) begin
      if (CFG_NUM_ROWS != '0) begin
        m_base    = CFG_BASE_ADDR;
        m_op      = CFG_OP;
        m_dest    = CFG_DEST;
        total     = int'(CFG_NUM_ROWS) * NUM_RF;
        beats_out = 0;
        busy_next = 1'b1;
      end else begin
        zero_next = 1'b1;
      end
    end
    stall_prev = bus.AXIS_M_TVALID && !bus.AXIS_M_TREADY;
    s_data = bus.AXIS_M_TDATA;
    s_user = bus.AXIS_M_TUSER;
    s_dest = bus.AXIS_M_TDEST;
    s_id   = bus.AXIS_M_TID;
    s_last = bus.AXIS_M_TLAST;
    busy_now  = busy_next;
    zero_now  = zero_next;
    drv_start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST = 1'b1;
    START = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.AXIS_M_TREADY = 1'b0;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_tvalid", bus.AXIS_M_TVALID, 1'b0);
    chk("rst_tdata", bus.AXIS_M_TDATA, '0);
    chk("rst_tuser", bus.AXIS_M_TUSER, '0);
    chk("rst_tdest", bus.AXIS_M_TDEST, '0);
    chk("rst_tid", bus.AXIS_M_TID, '0);
    chk("rst_tlast", bus.AXIS_M_TLAST, 1'b0);
    chk("rst_in_ready", bus.IN_READY, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    in_q.delete();
    busy_now   = 1'b0;
    zero_now   = 1'b0;
    stall_prev = 1'b0;
    beats_out  = 0;
    total      = 0;
  endtask

  // Starts a job, then streams with the given valid/ready percentages until DONE.
  task automatic run_job(input logic [ADDRW-1:0] base, input int rows, input logic [1:0] op,
                         input logic [DESTW-1:0] dest, input int ivp, input int trp,
                         input int mid_start_at, input int stop_at, input int exp_cycles);
    int n;
    CFG_BASE_ADDR = base;
    CFG_NUM_ROWS  = (ADDRW+1)'(rows);
    CFG_OP        = op;
    CFG_DEST      = dest;
    drv_start     = 1'b1;
    cycle(1'b0, 1'b1);
    n = 0;
    while (busy_now && n < LIMIT && !(stop_at >= 0 && beats_out >= stop_at)) begin
      if (n == mid_start_at) begin
        drv_start     = 1'b1;
        CFG_BASE_ADDR = ADDRW'($urandom());
        CFG_NUM_ROWS  = (ADDRW+1)'($urandom_range(5, 1));
        CFG_OP        = 2'b01;
        CFG_DEST      = DESTW'($urandom());
      end
      cycle($urandom_range(99) < ivp, $urandom_range(99) < trp);
      n++;
    end
    if (stop_at < 0) begin
      chk("job_finished", busy_now, 1'b0);
      chk("beats_total", beats_out, total);
      chk("words_all_sent", in_q.size(), 0);
      if (exp_cycles >= 0) chk("job_cycles", n, exp_cycles);
    end else begin
      chk("reached_stop", beats_out, stop_at);
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    drv_start = 1'b0;
    CFG_DEST = '0;
    CFG_BASE_ADDR = '0;
    CFG_NUM_ROWS = '0;
    CFG_OP = '0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = '0;
    bus.AXIS_M_TREADY = 1'b0;
    do_reset(3);

    // One row, continuous flow: 64 beats, no bubbles, DONE on the last handshake.
    run_job(9'h001, 1, 2'b11, 12'h002, 100, 100, -1, -1, NUM_RF + 1);
    // Address wrap 0x1FF -> 0x000 -> 0x001, with an ignored START mid-job.
    run_job(9'h1FF, 3, 2'b11, 12'h0A5, 100, 100, 20, -1, 3 * NUM_RF + 1);
    // Backpressure and gapped input.
    run_job(9'($urandom()), 2, 2'b11, 12'($urandom()), 60, 50, -1, -1, -1);

    // Zero-row job: DONE next cycle, never busy, no words taken.
    CFG_NUM_ROWS = '0;
    drv_start = 1'b1;
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b1);
    chk("zero_rows_no_beats", in_q.size(), 0);

    // Reset mid-job after 10 beats, then a fresh job from row 0x010.
    run_job(9'h050, 2, 2'b11, 12'h3C3, 80, 70, -1, 10, -1);
    do_reset(1);
    repeat (3) cycle(1'b1, 1'b1);
    run_job(9'h010, 1, 2'b11, 12'h011, 70, 60, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
